// File: rtl/leaf_switch.sv
// Leaf switch: 4 NI leaf ports + 1 uplink, per-input FIFOs, round-robin output arbitration.
// Optional saturating drop counter enabled by defining LEAF_SW_DROP_CNT_EN.
module leaf_switch #(
    parameter int GROUP_ID      = 6,
    parameter int DATA_W        = 16,
    parameter int IN_FIFO_DEPTH = 4,
    localparam int NPORTS       = 5
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NPORTS*DATA_W-1:0] in_data,
    input  logic [NPORTS-1:0]        in_valid,
    output logic [NPORTS-1:0]        in_ready,
    output logic [NPORTS*DATA_W-1:0] out_data,
    output logic [NPORTS-1:0]        out_valid,
    input  logic [NPORTS-1:0]        out_ready
`ifdef LEAF_SW_DROP_CNT_EN
    ,
    output logic [7:0]               drop_count
`endif
);

    localparam int PTR_W = $clog2(IN_FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [DATA_W-1:0] mem [NPORTS][IN_FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr [NPORTS];
    logic [PTR_W-1:0]  rd_ptr [NPORTS];
    logic [CNT_W-1:0]  count [NPORTS];
    logic [DATA_W-1:0] head [NPORTS];
    logic [2:0]        dest [NPORTS];
    logic [NPORTS-1:0] req [NPORTS];
    logic [NPORTS-1:0] gnt [NPORTS];
    logic [2:0]        sel [NPORTS];
    logic [2:0]        rr_ptr [NPORTS];
    logic [NPORTS-1:0] push;
    logic [NPORTS-1:0] pop;
    logic [NPORTS-1:0] head_valid;
    logic [NPORTS-1:0] drop;
    logic [NPORTS-1:0] load;

    // in_ready ignores a same-cycle pop so it never depends on arbitration
    always_comb begin
        for (int p = 0; p < NPORTS; p++) begin
            head_valid[p] = (count[p] != '0);
            in_ready[p]   = (count[p] != CNT_W'(IN_FIFO_DEPTH));
            push[p]       = in_valid[p] && in_ready[p];
            head[p]       = mem[p][rd_ptr[p]];
        end
    end

    always_comb begin
        for (int p = 0; p < NPORTS; p++) begin
            dest[p] = 3'd0;
            drop[p] = 1'b0;
            if (head_valid[p]) begin
                if (head[p][DATA_W-1 -: 4] == 4'(GROUP_ID)) begin
                    dest[p] = {1'b0, head[p][DATA_W-5 -: 2]};
                end else if (head[p][DATA_W-1 -: 4] == 4'd0 || p == NPORTS - 1) begin
                    drop[p] = 1'b1;
                end else begin
                    dest[p] = 3'd4;
                end
            end
        end
    end

    // Round-robin search per output, starting from that output's pointer
    always_comb begin
        pop = drop;
        for (int o = 0; o < NPORTS; o++) begin
            load[o] = !out_valid[o] || out_ready[o];
            gnt[o]  = '0;
            sel[o]  = 3'd0;
            for (int i = 0; i < NPORTS; i++) begin
                req[o][i] = head_valid[i] && !drop[i] && (dest[i] == 3'(o));
            end
            for (int k = 0; k < NPORTS; k++) begin
                automatic int idx = (int'(rr_ptr[o]) + k) % NPORTS;
                if (load[o] && !(|gnt[o]) && req[o][idx]) begin
                    gnt[o][idx] = 1'b1;
                    sel[o]      = 3'(idx);
                end
            end
            pop = pop | gnt[o];
        end
    end

    always_ff @(posedge clk) begin
        for (int p = 0; p < NPORTS; p++) begin
            if (push[p]) begin
                mem[p][wr_ptr[p]] <= in_data[p*DATA_W +: DATA_W];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int p = 0; p < NPORTS; p++) begin
                wr_ptr[p] <= '0;
                rd_ptr[p] <= '0;
                count[p]  <= '0;
            end
        end else begin
            for (int p = 0; p < NPORTS; p++) begin
                if (push[p]) wr_ptr[p] <= wr_ptr[p] + 1'b1;
                if (pop[p])  rd_ptr[p] <= rd_ptr[p] + 1'b1;
                if (push[p] && !pop[p])      count[p] <= count[p] + 1'b1;
                else if (!push[p] && pop[p]) count[p] <= count[p] - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_data  <= '0;
            out_valid <= '0;
            for (int o = 0; o < NPORTS; o++) rr_ptr[o] <= 3'd0;
        end else begin
            for (int o = 0; o < NPORTS; o++) begin
                if (|gnt[o]) begin
                    out_data[o*DATA_W +: DATA_W] <= head[sel[o]];
                    out_valid[o] <= 1'b1;
                    rr_ptr[o]    <= (sel[o] == 3'd4) ? 3'd0 : sel[o] + 3'd1;
                end else if (out_ready[o]) begin
                    out_valid[o] <= 1'b0;
                end
            end
        end
    end

`ifdef LEAF_SW_DROP_CNT_EN
    logic [2:0] n_drop;
    logic [8:0] drop_sum;

    always_comb begin
        n_drop = 3'd0;
        for (int p = 0; p < NPORTS; p++) n_drop = n_drop + 3'(drop[p]);
        drop_sum = {1'b0, drop_count} + 9'(n_drop);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) drop_count <= 8'd0;
        else       drop_count <= (drop_sum > 9'd255) ? 8'hFF : drop_sum[7:0];
    end
`endif

endmodule

// File: tb/tb_leaf_switch.sv
// Self-checking bench for leaf_switch: queue-based reference model compared every cycle,
// plus directed scenarios with literal expectations.
module tb_leaf_switch;
    localparam int DW = 16;
    localparam int NP = 5;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic [NP*DW-1:0] in_data;
    logic [NP*DW-1:0] out_data;
    logic [NP-1:0] in_valid;
    logic [NP-1:0] in_ready;
    logic [NP-1:0] out_valid;
    logic [NP-1:0] out_ready;
`ifdef LEAF_SW_DROP_CNT_EN
    logic [7:0] drop_count;
`endif

    int n_compared = 0;
    int n_mismatched = 0;

    logic [DW-1:0] mq [NP][$];
    bit            m_ov [NP];
    logic [DW-1:0] m_od [NP];
    int            m_rr [NP];
    int            m_drops;

    leaf_switch #(.GROUP_ID(6), .DATA_W(16), .IN_FIFO_DEPTH(4)) dut (
        .clk(clk),
        .reset(reset),
        .in_data(in_data),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .out_data(out_data),
        .out_valid(out_valid),
        .out_ready(out_ready)
`ifdef LEAF_SW_DROP_CNT_EN
        ,
        .drop_count(drop_count)
`endif
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [79:0] act, input logic [79:0] exp);
        n_compared++;
        if (act !== exp) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < NP; i++) begin
            mq[i].delete();
            m_ov[i] = 1'b0;
            m_od[i] = '0;
            m_rr[i] = 0;
        end
        m_drops = 0;
    endtask

    // One clock of the switch, phrased directly from the routing/arbitration rules
    task automatic model_step();
        bit acc [NP];
        int dest [NP];
        int nd;
        logic [DW-1:0] h;
        int grp;
        for (int i = 0; i < NP; i++) begin
            acc[i] = in_valid[i] && (mq[i].size() < DEPTH);
            dest[i] = -1;
            if (mq[i].size() > 0) begin
                h = mq[i][0];
                grp = int'(h[15:12]);
                if (grp == 6) dest[i] = int'(h[11:10]);
                else if (grp == 0 || i == 4) dest[i] = 5;
                else dest[i] = 4;
            end
        end
        nd = 0;
        for (int i = 0; i < NP; i++) begin
            if (dest[i] == 5) begin
                void'(mq[i].pop_front());
                nd++;
            end
        end
        for (int o = 0; o < NP; o++) begin
            if (!m_ov[o] || out_ready[o]) begin
                bit granted = 1'b0;
                for (int k = 0; k < NP; k++) begin
                    int i = (m_rr[o] + k) % NP;
                    if (!granted && dest[i] == o) begin
                        m_od[o] = mq[i][0];
                        void'(mq[i].pop_front());
                        m_rr[o] = (i + 1) % NP;
                        granted = 1'b1;
                    end
                end
                m_ov[o] = granted;
            end
        end
        for (int i = 0; i < NP; i++) begin
            if (acc[i]) mq[i].push_back(in_data[i*DW +: DW]);
        end
        m_drops = (m_drops + nd > 255) ? 255 : m_drops + nd;
    endtask

    initial begin
        forever begin
            @(posedge clk or posedge reset);
            if (reset) model_clear();
            else model_step();
        end
    end

    task automatic compare_model();
        logic [79:0] eod;
        logic [4:0] eov;
        logic [4:0] eir;
        for (int o = 0; o < NP; o++) begin
            eov[o] = m_ov[o];
            eod[o*DW +: DW] = m_od[o];
            eir[o] = (mq[o].size() < DEPTH);
        end
        checkOutput("model_out_valid", 80'(out_valid), 80'(eov));
        checkOutput("model_out_data", out_data, eod);
        checkOutput("model_in_ready", 80'(in_ready), 80'(eir));
`ifdef LEAF_SW_DROP_CNT_EN
        checkOutput("model_drop_count", 80'(drop_count), 80'(m_drops));
`endif
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (reset === 1'b0) compare_model();
        end
    end

    task automatic next_cycle();
        @(negedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [79:0] d, input logic [4:0] v, input logic [4:0] r);
        in_data = d;
        in_valid = v;
        out_ready = r;
        next_cycle();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        in_valid = '0;
        in_data = '0;
        out_ready = '1;
        next_cycle();
        next_cycle();
        reset = 1'b0;
    endtask

    logic [79:0] d;
    logic [15:0] rec [$];
    int first_c;
    int last_c;
    int k;

    initial begin
        in_valid = '0;
        in_data = '0;
        out_ready = '1;
        reset = 1'b1;
        next_cycle();
        checkOutput("reset_out_valid", 80'(out_valid), 80'(0));
        checkOutput("reset_out_data", out_data, 80'(0));
        checkOutput("reset_in_ready", 80'(in_ready), 80'(5'b11111));
        next_cycle();
        reset = 1'b0;

        // Single flit leaf1 -> leaf0, 2-cycle latency
        d = '0; d[1*DW +: DW] = 16'h6155;
        applyStimulus(d, 5'b00010, 5'b11111);
        checkOutput("lat_not_early", 80'(out_valid), 80'(0));
        applyStimulus('0, 5'b00000, 5'b11111);
        checkOutput("lat_out_valid", 80'(out_valid), 80'(5'b00001));
        checkOutput("lat_out_data", 80'(out_data[0*DW +: DW]), 80'(16'h6155));

        // Foreign group goes up; uplink traffic for our group comes down
        d = '0; d[0*DW +: DW] = 16'h8C01;
        applyStimulus(d, 5'b00001, 5'b11111);
        applyStimulus('0, 5'b00000, 5'b11111);
        checkOutput("up_out_valid", 80'(out_valid), 80'(5'b10000));
        checkOutput("up_out_data", 80'(out_data[4*DW +: DW]), 80'(16'h8C01));
        d = '0; d[4*DW +: DW] = 16'h6803;
        applyStimulus(d, 5'b10000, 5'b11111);
        applyStimulus('0, 5'b00000, 5'b11111);
        checkOutput("down_out_valid", 80'(out_valid), 80'(5'b00100));
        checkOutput("down_out_data", 80'(out_data[2*DW +: DW]), 80'(16'h6803));

        // Four inputs contend for leaf 3
        do_reset();
        rec.delete();
        first_c = -1;
        last_c = -1;
        for (int c = 0; c < 16; c++) begin
            if (out_valid[3]) begin
                rec.push_back(out_data[3*DW +: DW]);
                if (first_c < 0) first_c = c;
                last_c = c;
            end
            d = '0;
            if (c < 3) for (int p = 0; p < 4; p++) d[p*DW +: DW] = 16'h6C00 + 16'(p*16 + c);
            applyStimulus(d, (c < 3) ? 5'b01111 : 5'b00000, 5'b11111);
        end
        checkOutput("rr_count", 80'(rec.size()), 80'(12));
        checkOutput("rr_span", 80'(last_c - first_c), 80'(11));
        for (int j = 0; j < 12; j++) begin
            logic [15:0] e;
            logic [15:0] a;
            e = 16'h6C00 + 16'((j % 4) * 16 + j / 4);
            a = (j < rec.size()) ? rec[j] : 16'hXXXX;
            checkOutput($sformatf("rr_order_%0d", j), 80'(a), 80'(e));
        end

        // Backpressure on leaf 2
        do_reset();
        k = 0;
        for (int c = 0; c < 8; c++) begin
            bit acc;
            d = '0; d[0*DW +: DW] = 16'h6800 + 16'(k);
            in_data = d;
            in_valid = 5'b00001;
            out_ready = 5'b11011;
            acc = in_ready[0];
            next_cycle();
            if (acc) k++;
        end
        checkOutput("bp_accepted", 80'(k), 80'(5));
        checkOutput("bp_in_ready", 80'(in_ready[0]), 80'(0));
        checkOutput("bp_held_data", 80'(out_data[2*DW +: DW]), 80'(16'h6800));
        rec.delete();
        for (int c = 0; c < 8; c++) begin
            in_valid = '0;
            out_ready = 5'b11111;
            if (out_valid[2]) rec.push_back(out_data[2*DW +: DW]);
            next_cycle();
        end
        checkOutput("bp_drain_count", 80'(rec.size()), 80'(5));
        for (int j = 0; j < 5; j++) begin
            logic [15:0] a;
            a = (j < rec.size()) ? rec[j] : 16'hXXXX;
            checkOutput($sformatf("bp_drain_%0d", j), 80'(a), 80'(16'h6800 + 16'(j)));
        end

        // Drops: group 0 and uplink foreign group
        do_reset();
        d = '0; d[1*DW +: DW] = 16'h0000; d[4*DW +: DW] = 16'h8C00;
        applyStimulus(d, 5'b10010, 5'b11111);
        for (int c = 0; c < 3; c++) begin
            applyStimulus('0, 5'b00000, 5'b11111);
            checkOutput("drop_no_valid", 80'(out_valid), 80'(0));
        end
`ifdef LEAF_SW_DROP_CNT_EN
        checkOutput("drop_count_2", 80'(drop_count), 80'(2));
`endif
        d = '0;
        for (int c = 0; c < 300; c++) applyStimulus(d, 5'b00010, 5'b11111);
        for (int c = 0; c < 3; c++) applyStimulus('0, 5'b00000, 5'b11111);
        checkOutput("drop_many_no_valid", 80'(out_valid), 80'(0));
`ifdef LEAF_SW_DROP_CNT_EN
        checkOutput("drop_count_sat", 80'(drop_count), 80'(255));
`endif

        // Reset with traffic in flight
        do_reset();
        for (int c = 0; c < 4; c++) begin
            d = '0; d[1*DW +: DW] = 16'h6155 + 16'(c);
            applyStimulus(d, 5'b00010, 5'b11110);
        end
        checkOutput("pre_reset_valid", 80'(out_valid[0]), 80'(1));
        in_valid = '0;
        reset = 1'b1;
        #1;
        checkOutput("async_reset_valid", 80'(out_valid), 80'(0));
        next_cycle();
        reset = 1'b0;
        checkOutput("post_reset_in_ready", 80'(in_ready), 80'(5'b11111));
        for (int c = 0; c < 5; c++) begin
            applyStimulus('0, 5'b00000, 5'b11111);
            checkOutput("no_stale_flit", 80'(out_valid), 80'(0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end
endmodule
